// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial addition of two WIDTH-bit operands plus carry-in
// Ports: clk rising-edge clock; rst_n async active-low reset; start requests an addition;
//        a, b operands and cin carry-in, sampled on the load edge; busy high while bits are
//        processed; done one-clock pulse when sum/cout are valid; sum/cout registered result.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
  logic [CW-1:0] cnt;
  logic carry, s, c_nx, last;
  always_comb begin
    s = a_sh[0] ^ b_sh[0] ^ carry;
    c_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // new sum bit enters at the MSB; the oldest bit falls off the bottom
    r_nx = WIDTH'({s, r_sh} >> 1);
    last = cnt == CW'(WIDTH - 1);
    nxt = st == IDLE ? (start ? RUN : IDLE) : st == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (st == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      carry <= cin;
      cnt <= '0;
    end else if (st == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nx;
      carry <= c_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= r_nx;
        cout <= c_nx;
      end
    end
  assign busy = st == RUN;
  assign done = st == DONE;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed checks of bit_serial_adder at WIDTH=8 and WIDTH=1
module tb_bit_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  int checks = 0, errors = 0;
  logic [7:0] last_sum = '0;
  logic last_cout = 1'b0;
  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  bit_serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input bit disturb);
    int k, nb;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    nb = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      start8 = disturb && k == 3;
      if (disturb) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (done8) break;
      nb += int'(busy8);
      if (k == 2) chk("hold_sum", {24'd0, sum8}, {24'd0, last_sum});
      if (k == 2) chk("hold_cout", {31'd0, cout8}, {31'd0, last_cout});
    end
    start8 = 1'b0;
    chk("done_latency", k, 8);
    chk("busy_cycles", nb, 8);
    chk("sum", {24'd0, sum8}, {24'd0, es});
    chk("cout", {31'd0, cout8}, {31'd0, ec});
    last_sum = es; last_cout = ec;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done8}, 0);
    @(negedge clk);
    chk("no_extra_op", {30'd0, busy8, done8}, 0);
  endtask

  initial begin
    int k, nd, prev;
    #2;
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_sum", {24'd0, sum8}, 0);
    chk("rst_cout", {31'd0, cout8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run8(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 0);
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
    run8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1);
    // start held high: done every WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    nd = 0; prev = -1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) begin
        nd++;
        chk("stream_sum", {24'd0, sum8}, 32'h46);
        if (prev >= 0) chk("stream_period", k - prev, 10);
        prev = k;
      end
    end
    start8 = 1'b0;
    chk("stream_count", nd, 3);
    repeat (3) @(negedge clk);
    chk("stream_idle", {31'd0, busy8}, 0);
    // reset on the 4th RUN cycle aborts the operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'd0, busy8}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy8, done8, cout8, sum8}, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(done8);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      nd += int'(done8);
    end
    chk("abort_no_done", nd, 0);
    last_sum = '0; last_cout = 1'b0;
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);
    // WIDTH=1 full-adder truth table, expected {cout,sum} per {a,b,cin}
    for (int v = 0; v < 8; v++) begin
      logic [1:0] tt [8];
      tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      @(negedge clk);
      {a1, b1, cin1} = 3'(v);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
      @(negedge clk);
      chk("w1_done", {31'd0, done1}, 1);
      chk("w1_result", {30'd0, cout1, sum1}, {30'd0, tt[v]});
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH SHALL default to 8 and give the operand and sum width; legal range is 1..32.
REQ-003 Port clk SHALL be an input, 1 bit wide, and serve as the rising-edge clock.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous active-low reset.
REQ-005 Port start SHALL be an input, 1 bit wide, and request a new addition.
REQ-006 Port a SHALL be an input, WIDTH bits wide, and carry operand A.
REQ-007 Port b SHALL be an input, WIDTH bits wide, and carry operand B.
REQ-008 Port cin SHALL be an input, 1 bit wide, and carry the carry-in for bit 0.
REQ-009 Port busy SHALL be an output, 1 bit wide, and be high while bit-serial computation is in progress.
REQ-010 Port done SHALL be an output, 1 bit wide, and pulse for one clock when the result is valid.
REQ-011 Port sum SHALL be an output, WIDTH bits wide, and carry the registered result.
REQ-012 Port cout SHALL be an output, 1 bit wide, and carry the registered final carry-out.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 In IDLE, a rising edge with start=1 SHALL load a and b into operand shift registers, load cin into the carry flip-flop, clear the bit counter, and enter RUN.
REQ-015 In RUN, each rising edge SHALL compute one full-adder step on a_sh[0], b_sh[0] and carry:
  - sum bit = XOR of the three inputs;
  - carry = majority of the three inputs.
REQ-016 In RUN, each edge SHALL shift the sum bit into the MSB of the result shift register, shift both operands right by one, store the new carry, and increment the counter.
REQ-017 On the edge that processes bit WIDTH-1, the block SHALL copy the full result into sum and the final carry into cout, then enter DONE.
REQ-018 DONE SHALL last exactly one clock and then return to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high from edge E_WIDTH to edge E_WIDTH+1.
REQ-020 busy SHALL be high exactly while the state is RUN, which is WIDTH cycles.
REQ-021 sum and cout SHALL change only when entering DONE; partial results SHALL never appear on them.
REQ-022 sum and cout SHALL hold their last value until the next completed operation.
REQ-023 start SHALL be ignored in RUN and in DONE.
REQ-024 Changes on a, b or cin after the load edge SHALL NOT affect the operation in progress.
REQ-025 If start is held high continuously, a new operation SHALL begin on the first edge in IDLE after DONE, giving a period of WIDTH+2 cycles.
REQ-026 Overflow SHALL wrap modulo 2^WIDTH, with the overflow bit reported on cout.
REQ-027 {cout, sum} SHALL always equal a + b + cin as loaded.
REQ-028 The counter SHALL be wide enough to hold WIDTH-1 without wrapping for every legal WIDTH.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE and clear all of the following to 0:
  - busy, done, sum, cout;
  - both operand shift registers, the result shift register, the carry flip-flop and the counter.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the first start after release SHALL produce a correct result.
REQ-031 Reset release SHALL take effect on the next rising edge; a start seen on that edge SHALL be accepted.

Verification
REQ-032 With WIDTH=8, start pulse with a=0x00, b=0x00, cin=0 -> busy high for 8 cycles, done pulses 8 edges after start, sum=0x00, cout=0.
REQ-033 With WIDTH=8:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1;
  - a=0x7F, b=0x01, cin=1 -> sum=0x81, cout=0;
  - a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-034 With WIDTH=8, toggle a, b and cin and pulse start during RUN -> the result matches the originally loaded operands and no extra operation starts.
REQ-035 With WIDTH=8, hold start=1 for 30 cycles with fixed operands 0x12+0x34, cin=0 -> done pulses every 10 cycles and sum=0x46 each time.
REQ-036 With WIDTH=8, assert rst_n=0 on the 4th RUN cycle -> all outputs read 0 immediately and no done pulse occurs; after release, 0x10+0x20 gives sum=0x30.
REQ-037 With WIDTH=1, apply all 8 {a,b,cin} combinations -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> 1,1), with done one edge after start.
